// File: rtl/sram_pkg.sv
// Shared constants and helpers for the pipelined SRAM board model.
// Pure compile-time package: no latency, no flow control.
// Byte-lane mask expansion is sized to the widest supported bus and truncated at use.
package sram_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 18;
    localparam int DEF_DEPTH    = 256;
    localparam int DEF_READ_LAT = 2;
    localparam int MAX_DATA_W   = 256;
    localparam int MAX_BE       = MAX_DATA_W / 8;

    function automatic int clog2(input int unsigned v);
        int unsigned p;
        int          r;
        p = 1;
        r = 0;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Active-low lane enables -> active-high bit mask, one byte per lane.
    function automatic logic [MAX_DATA_W-1:0] be_mask(input logic [MAX_BE-1:0] be_n);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BE; i++) begin
            m[8*i +: 8] = {8{~be_n[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data delay line of {valid, data} pairs with async active-low clear.
// Latency: LAT clock edges from in_* to out_*; one word per cycle throughput.
// No backpressure: the line advances every clock and the consumer must take the word.
module sram_rd_pipe #(
    parameter int DATA_W = 16,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_dat
);

    logic [LAT-1:0]             vld_q, vld_d;
    logic [LAT-1:0][DATA_W-1:0] dat_q, dat_d;

    always_comb begin
        vld_d    = vld_q;
        dat_d    = dat_q;
        vld_d[0] = in_vld;
        dat_d[0] = in_dat;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_vld = vld_q[LAT-1];
    assign out_dat = dat_q[LAT-1];

endmodule

// File: rtl/sram_model_pipe.sv
// Behavioural external SRAM with byte lanes, CE/OE/WE and a fixed pipelined read latency.
// Latency: request at edge N drives DQ in the cycle after edge N+READ_LAT-1.
// No backpressure: a read word not drivable in its slot (OE_N high or WE_N low) is lost.
// SRAM_BOUNDS_CHECK_EN: drop/zero out-of-range accesses and count them in err_cnt.
module sram_model_pipe
    import sram_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter int                READ_LAT = DEF_READ_LAT,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SRAM_CE_N,
    input  logic                SRAM_WE_N,
    input  logic                SRAM_OE_N,
    input  logic [DATA_W/8-1:0] SRAM_BE_N,
    input  logic [ADDR_W-1:0]   SRAM_ADDR,
    inout  wire  [DATA_W-1:0]   SRAM_DQ,
    output logic                rd_valid,
    output logic [7:0]          err_cnt
);

    localparam int AW = clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] lane_mask;
    logic              in_range;
    logic              wr_en;
    logic              rd_req;
    logic [DATA_W-1:0] rd_dat;
    logic              pipe_vld;
    logic [DATA_W-1:0] pipe_dat;
    logic              drv;

    assign idx       = SRAM_ADDR[AW-1:0];
    assign lane_mask = DATA_W'(be_mask(MAX_BE'(SRAM_BE_N)));

`ifdef SRAM_BOUNDS_CHECK_EN
    logic [7:0] err_q, err_d;

    assign in_range = ((SRAM_ADDR >> AW) == '0);

    always_comb begin
        err_d = err_q;
        if (!SRAM_CE_N && !in_range && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`else
    assign in_range = 1'b1;
    assign err_cnt  = '0;
`endif

    assign wr_en  = !SRAM_CE_N && !SRAM_WE_N && in_range;
    assign rd_req = !SRAM_CE_N && SRAM_WE_N;
    // Read data is frozen at request time so later writes cannot reach in-flight words.
    assign rd_dat = in_range ? (mem_q[idx] & lane_mask) : '0;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[idx] = (mem_q[idx] & ~lane_mask) | (SRAM_DQ & lane_mask);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT_VAL;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    sram_rd_pipe #(
        .DATA_W (DATA_W),
        .LAT    (READ_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst),
        .in_vld  (rd_req),
        .in_dat  (rd_dat),
        .out_vld (pipe_vld),
        .out_dat (pipe_dat)
    );

    // A controller write in the output slot wins the bus; the read word is dropped.
    assign drv      = pipe_vld && !SRAM_OE_N && SRAM_WE_N;
    assign rd_valid = drv;
    assign SRAM_DQ  = drv ? pipe_dat : 'z;

endmodule

// File: tb/tb_sram_model_pipe.sv
// Scoreboard bench for sram_model_pipe: array reference model, expected reads queued with their bus slot.
// Directed scenarios first, then randomized read/write/idle/contention traffic.
module tb_sram_model_pipe;

    localparam int          DATA_W   = 16;
    localparam int          ADDR_W   = 18;
    localparam int          DEPTH    = 256;
    localparam int          READ_LAT = 2;
    localparam logic [15:0] INIT     = 16'hA5A5;

    logic              clk;
    logic              rst;
    logic              ce_n, we_n, oe_n;
    logic [1:0]        be_n;
    logic [ADDR_W-1:0] addr;
    logic              tb_oe;
    logic [15:0]       tb_dat;
    wire  [15:0]       dq;
    logic              rd_valid;
    logic [7:0]        err_cnt;

    assign dq = tb_oe ? tb_dat : 'z;

    sram_model_pipe #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .READ_LAT (READ_LAT),
        .INIT_VAL (INIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SRAM_CE_N (ce_n),
        .SRAM_WE_N (we_n),
        .SRAM_OE_N (oe_n),
        .SRAM_BE_N (be_n),
        .SRAM_ADDR (addr),
        .SRAM_DQ   (dq),
        .rd_valid  (rd_valid),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        int          due;
        logic [15:0] dat;
    } exp_t;

    logic [15:0] ref_mem [DEPTH];
    exp_t        sb_q [$];
    int          err_exp;
    int          edge_n;
    int          n_tests;
    int          n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        edge_n = 0;
        forever begin
            @(posedge clk);
            edge_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h required %h", nm, edge_n, got, exp);
        end
    endtask

    // Monitor: every cycle the bus must carry exactly what the model says is due.
    initial begin
        exp_t item;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0 && sb_q[0].due == edge_n) begin
                item = sb_q.pop_front();
                if (!oe_n && we_n) begin
                    check("rd_valid_slot", 32'(rd_valid), 32'd1);
                    check("rd_data", 32'(dq), 32'(item.dat));
                end else begin
                    check("rd_suppressed", 32'(rd_valid), 32'd0);
                end
            end else begin
                check("rd_idle", 32'(rd_valid), 32'd0);
            end
        end
    end

    task automatic model_reset();
        sb_q.delete();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT;
        err_exp = 0;
    endtask

    task automatic model_write(input int a, input logic [15:0] d, input logic [1:0] be);
        int w;
`ifdef SRAM_BOUNDS_CHECK_EN
        if (a >= DEPTH) begin
            err_exp++;
            return;
        end
`endif
        w = a % DEPTH;
        for (int b = 0; b < 2; b++) begin
            if (!be[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic model_read(input int a, input logic [1:0] be);
        exp_t        e;
        logic [15:0] v;
        v = ref_mem[a % DEPTH];
`ifdef SRAM_BOUNDS_CHECK_EN
        if (a >= DEPTH) begin
            v = '0;
            err_exp++;
        end
`endif
        for (int b = 0; b < 2; b++) begin
            if (be[b]) v[8*b +: 8] = 8'h00;
        end
        e.due = edge_n + READ_LAT;
        e.dat = v;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input logic [15:0] d, input logic [1:0] be);
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; be_n = be;
        addr = ADDR_W'(a); tb_dat = d; tb_oe = 1'b1;
        model_write(a, d, be);
        tick();
        tb_oe = 1'b0;
    endtask

    task automatic do_read(input int a, input logic [1:0] be, input logic oe);
        ce_n = 1'b0; we_n = 1'b1; oe_n = oe; be_n = be;
        addr = ADDR_W'(a); tb_oe = 1'b0;
        model_read(a, be);
        tick();
    endtask

    task automatic do_idle(input int n, input logic we, input logic oe);
        repeat (n) begin
            ce_n = 1'b1; we_n = we; oe_n = oe; tb_oe = 1'b0;
            addr = ADDR_W'($urandom_range(0, 511));
            tick();
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int r;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
        be_n = 2'b00; addr = '0; tb_oe = 1'b0; tb_dat = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
        tick();

        // Reset contents and latency of a single read.
        do_read(7, 2'b00, 1'b0);
        do_idle(4, 1'b1, 1'b0);

        // Full write then lane-0-only write.
        do_write(3, 16'h1234, 2'b00);
        do_write(3, 16'hFFFF, 2'b10);
        do_read(3, 2'b00, 1'b0);
        do_idle(3, 1'b1, 1'b0);

        // Back-to-back burst.
        for (int i = 0; i < 4; i++) do_write(i, 16'(16'h10 + i), 2'b00);
        for (int i = 0; i < 4; i++) do_read(i, 2'b00, 1'b0);
        do_idle(3, 1'b1, 1'b0);

        // In-flight read is immune to a following write.
        do_write(5, 16'h0055, 2'b00);
        do_read(5, 2'b00, 1'b0);
        do_write(5, 16'hBEEF, 2'b00);
        do_idle(3, 1'b1, 1'b0);
        do_read(5, 2'b00, 1'b0);
        do_idle(3, 1'b1, 1'b0);

        // Reset while a read is in flight.
        do_read(9, 2'b00, 1'b0);
        ce_n = 1'b1; oe_n = 1'b0;
        pulse_reset();
        do_idle(3, 1'b1, 1'b0);
        do_read(3, 2'b00, 1'b0);
        do_idle(3, 1'b1, 1'b0);

        // Address beyond DEPTH: dropped and counted, or wrapped.
        do_write(300, 16'hC0DE, 2'b00);
        check("err_cnt_after_oor_write", 32'(err_cnt), 32'(err_exp));
        do_read(44, 2'b00, 1'b0);
        do_read(300, 2'b00, 1'b0);
        do_idle(3, 1'b1, 1'b0);
        check("err_cnt_after_oor_read", 32'(err_cnt), 32'(err_exp));

        // Randomized traffic including OE/WE contention in output slots.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                do_read($urandom_range(0, 299), 2'($urandom_range(0, 3)),
                        ($urandom_range(0, 3) == 0));
            end else if (r <= 6) begin
                do_write($urandom_range(0, 299), 16'($urandom()), 2'($urandom_range(0, 3)));
            end else if (r <= 8) begin
                do_idle(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                do_idle(1, 1'b1, 1'b0);
            end
        end
        do_idle(READ_LAT + 2, 1'b1, 1'b0);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("err_cnt_final", 32'(err_cnt), 32'((err_exp > 255) ? 255 : err_exp));

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_model_pipe.md
Name: sram_model_pipe

Overview:
- Parametrised behavioural model of an external asynchronous-style SRAM for board-level simulation of the memory-stage controller.
- Adds several features the single-cycle model lacked:
  - configurable width and depth
  - byte-lane masks (UB/LB)
  - chip and output enables
  - a fixed, pipelined read latency in clock cycles
  - a read-valid strobe for the bench
- Sits between the SRAM controller's pad signals and the testbench; it is not synthesised.

Parameters:
- DATA_W, 16, data bus width; must be a multiple of 8.
- ADDR_W, 18, address bus width.
- DEPTH, 256, number of implemented words; power of 2, ≤ 2**ADDR_W.
- READ_LAT, 2, clock cycles from read request to data on bus; range 1..8.
- INIT_VAL, 0, value loaded into every word at reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- SRAM_CE_N  in  1  chip enable, active-low.
- SRAM_WE_N  in  1  write enable, active-low.
- SRAM_OE_N  in  1  output enable, active-low.
- SRAM_BE_N  in  DATA_W/8  byte-lane enables, active-low; bit 0 = DQ[7:0].
- SRAM_ADDR  in  ADDR_W  word address.
- SRAM_DQ  inout  DATA_W  bidirectional data bus.
- rd_valid  out  1  high in cycles where the model drives SRAM_DQ with read data.
- err_cnt  out  8  saturating count of out-of-range accesses (see Optional Feature).

Behaviour:
- Reset (rst low, asynchronous):
  - every word = INIT_VAL
  - read pipeline flushed
  - SRAM_DQ = high-Z
  - rd_valid = 0
  - err_cnt = 0
- Reset mid-read: the pending read is discarded, and nothing is driven after rst rises.
- Write: at posedge clk with CE_N=0 and WE_N=0, each byte lane i with BE_N[i]=0 takes SRAM_DQ[8i+7:8i]. Lanes with BE_N[i]=1 keep their old value. All BE_N=1 means no change.
- Read request: at posedge clk with CE_N=0 and WE_N=1, the word at SRAM_ADDR is sampled into pipeline stage 0 together with a valid bit.
  - The data is captured at request time, so a later write to the same address does not alter an in-flight read.
  - Disabled lanes (BE_N=1 at request) read as 0.
- Pipeline: READ_LAT-deep shift register of {valid, data}, advancing every clk.
  - A request at edge N appears at stage READ_LAT-1 after edge N+READ_LAT-1.
  - Data is therefore on the bus for the cycle following edge N+READ_LAT-1.
  - Back-to-back requests give one word per cycle.
- Bus drive: SRAM_DQ = last-stage data when last-stage valid=1, OE_N=0 and WE_N=1; otherwise high-Z. rd_valid equals this same drive condition.
- Contention: if WE_N=0 in the output cycle, the driver is suppressed. That read word is lost, and rd_valid=0.
- CE_N=1 means no request or write is accepted. The pipeline keeps draining, and its output is still gated only by OE_N/WE_N.
- Write and read in the same cycle are impossible (WE_N selects one). A write at edge N followed by a read request to the same address at edge N+1 returns the new data.

Optional Feature:
- Macro: SRAM_BOUNDS_CHECK_EN.
- Defined:
  - A write with SRAM_ADDR ≥ DEPTH is dropped.
  - A read request with SRAM_ADDR ≥ DEPTH returns 0, with its valid bit still set.
  - Each such access increments err_cnt, saturating at 255.
- Undefined:
  - Addresses wrap modulo DEPTH (only the low log2(DEPTH) bits are used).
  - err_cnt is tied to 0.

Decomposition:
- Package sram_pkg:
  - default parameter constants
  - function clog2
  - byte-mask helper function (expand BE_N to a DATA_W bit mask)
- Sub-module sram_rd_pipe: parametrised {valid, data} shift register of depth READ_LAT with async active-low clear. The top level holds the memory array, write logic and bus driver.

Test Plan:
- Reset with INIT_VAL=16'hA5A5, then read address 7 → 16'hA5A5 on DQ exactly READ_LAT=2 cycles after the request, with rd_valid pulsing for 1 cycle.
- Write 16'h1234 at address 3 with all lanes enabled, then write 16'hFFFF with BE_N=2'b10, then read address 3 → 16'h12FF.
- Burst-read addresses 0..3 (preloaded with 0x10..0x13) on 4 consecutive cycles → 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles; rd_valid high for all 4.
- Issue a read of address 5 (holding 0x0055), then write 0xBEEF to address 5 on the next cycle → the read returns 0x0055. A later read returns 0xBEEF.
- Pull rst low for 1 cycle while a read is in flight → no drive, rd_valid stays 0, and memory returns INIT_VAL.
- With SRAM_BOUNDS_CHECK_EN defined, write address 300 with DEPTH=256 → memory is unchanged and err_cnt=1. Without the macro, the same write lands at address 44.
